// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MUL/MULHU/DIVU/REMU controller that steps the
// shared EX-stage ALU through ITER add/subtract iterations.
// Ports: clk, rst (sync, active-high), start/op/src_a/src_b request,
//   busy (CALC), done (one-cycle pulse), result (held until next done),
//   alu_a/alu_b/alu_ctrl to the ALU, alu_result back from the ALU.
module muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result
);

    localparam int CW = $clog2(ITER);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   opnd;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;

    logic          div_zero;
    logic          last;
    logic          carry;
    logic          ge;
    logic [31:0]   hi_nxt;
    logic [31:0]   lo_nxt;

    // op[1] selects divide; a zero divisor skips the iterations entirely
    assign div_zero = op[1] && (src_b == 32'd0);
    assign last     = (cnt == CW'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ALU drive: shift-add for multiply, restoring subtract for divide
    always_comb begin
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_ctrl = ALU_ADD;
        if (state == CALC) begin
            if (op_q[1]) begin
                alu_ctrl = ALU_SUB;
                alu_a    = {hi[30:0], lo[31]};
                alu_b    = opnd;
            end else begin
                alu_ctrl = ALU_ADD;
                alu_a    = hi;
                alu_b    = lo[0] ? opnd : 32'd0;
            end
        end
    end

    // Carry-out of the add and "no borrow" of the subtract, rebuilt from
    // operand and result MSBs. For divide, hi[31] is bit 32 of the shifted
    // partial remainder, which alone guarantees it exceeds the divisor.
    always_comb begin
        carry = (alu_a[31] & alu_b[31])
              | ((alu_a[31] | alu_b[31]) & ~alu_result[31]);
        ge    = hi[31]
              | (alu_a[31] & ~alu_b[31])
              | (~(alu_a[31] ^ alu_b[31]) & ~alu_result[31]);
        if (op_q[1]) begin
            hi_nxt = ge ? alu_result : alu_a;
            lo_nxt = {lo[30:0], ge};
        end else begin
            hi_nxt = {carry, alu_result[31:1]};
            lo_nxt = {alu_result[0], lo[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= 32'd0;
            lo     <= 32'd0;
            opnd   <= 32'd0;
            cnt    <= '0;
            op_q   <= 2'd0;
            result <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        hi   <= 32'd0;
                        lo   <= src_a;
                        opnd <= src_b;
                        cnt  <= '0;
                        if (div_zero) begin
                            result <= op[0] ? src_a : 32'hFFFF_FFFF;
                        end
                    end
                end
                CALC: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        // op[0] picks the upper half: MULHU and REMU
                        result <= op_q[0] ? hi_nxt : lo_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed bench for muldiv_sequencer
// against a plain-arithmetic reference, with a behavioural ALU attached.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;

    int npass;
    int ntot;

    muldiv_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = (alu_ctrl == 3'b001) ? (alu_a - alu_b)
                                          : (alu_a + alu_b);
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        if (obs === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_alu"}, alu_a | alu_b | {29'd0, alu_ctrl}, 32'd0);
    endtask

    task automatic run_op(input string tag,
                          input logic [1:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        logic [31:0] res;
        int cyc;
        int nbusy;
        int dcyc;
        int bad_ctrl;
        bit dz;
        exp      = model(o, a, b);
        dz       = o[1] && (b == 0);
        nbusy    = 0;
        dcyc     = 0;
        bad_ctrl = 0;
        res      = 32'd0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (dcyc == 0 && cyc <= 40) begin
            if (busy) begin
                nbusy++;
                if (alu_ctrl != {2'b00, o[1]}) bad_ctrl++;
            end
            if (done) begin
                dcyc = cyc;
                res  = result;
                chk({tag, "_alu_done"},
                    alu_a | alu_b | {29'd0, alu_ctrl}, 32'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_result"}, res, exp);
        chk({tag, "_done_cyc"}, dcyc, dz ? 1 : 33);
        chk({tag, "_busy_cnt"}, nbusy, dz ? 0 : 32);
        chk({tag, "_ctrl"}, bad_ctrl, 0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int cyc;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        npass = 0;
        ntot  = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_outs_zero("reset");
        chk("reset_result", result, 32'd0);

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6);
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op("divu_z", 2'b10, 32'h1234, 32'd0);
        run_op("remu_z", 2'b11, 32'h1234, 32'd0);

        // start pulses during CALC and DONE must be dropped
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'd1000;
        src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'd5;
        src_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 6;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("hs_done_cyc", cyc, 33);
        chk("hs_result", result, 32'd3000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hs_idle_busy", {31'd0, busy}, 32'd0);
        chk("hs_idle_done", {31'd0, done}, 32'd0);
        chk("hs_hold", result, 32'd3000);
        @(negedge clk);
        chk("hs_no_accept", {31'd0, done | busy}, 32'd0);

        // reset during iteration 10 of a divide
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_outs_zero("rst_mid");
        chk("rst_mid_result", result, 32'd0);
        run_op("mul_after_rst", 2'b00, 32'd12345, 32'd678);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the EX stage of the pipelined RISC-V core. Executes MUL, MULHU, DIVU and REMU by stepping the existing 32-bit ALU through 32 add or subtract iterations, driving its operand and control inputs and reading back its result. Sits beside the EX-stage ALU with a start/busy/done handshake. The hazard logic stalls the pipeline while `busy` is high.

## Interface
- `ITER`, 32, iteration count; fixed at the operand width.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  operation: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU
- `src_a`  in  32  multiplicand / dividend
- `src_b`  in  32  multiplier / divisor
- `busy`  out  1  high in CALC
- `done`  out  1  one-cycle pulse, high in DONE
- `result`  out  32  final value; valid from DONE, held until the next accepted start
- `alu_a`  out  32  ALU operand A
- `alu_b`  out  32  ALU operand B
- `alu_ctrl`  out  3  ALU control: 000 add, 001 subtract
- `alu_result`  in  32  ALU Result, combinational from `alu_a`, `alu_b` and `alu_ctrl`

## Operation
- States are IDLE, CALC and DONE.
  - IDLE→CALC on `start`, latching `op`, `src_a` and `src_b`.
  - IDLE→DONE on `start` with a divide op and `src_b`==0.
  - CALC→DONE after the 32nd iteration.
  - DONE→IDLE unconditionally.
- Internal registers: `hi`[31:0], `lo`[31:0], `opnd`[31:0], `cnt`[4:0] and `op_q`.
- The ALU Carry flag is not used. Carry and borrow are derived locally from operand and result MSBs.
- Multiply, on accept: `hi`=0, `lo`=`src_a`, `opnd`=`src_b`.
  - Each CALC cycle drives `alu_ctrl`=000, `alu_a`=`hi`, `alu_b`=`lo`[0] ? `opnd` : 0.
  - c = (a31&b31) | ((a31|b31) & ~r31).
  - {`hi`,`lo`} <= {c, `alu_result`, `lo`[31:1]}.
  - Result: MUL = `lo`, MULHU = `hi`.
- Divide (restoring), on accept: `hi`=0, `lo`=`src_a`, `opnd`=`src_b`.
  - Each CALC cycle drives `alu_ctrl`=001, `alu_a`={`hi`[30:0],`lo`[31]}, `alu_b`=`opnd`.
  - ge = `hi`[31] | (a31&~b31) | (~(a31^b31)&~r31).
  - `hi` <= ge ? `alu_result` : `alu_a`.
  - `lo` <= {`lo`[30:0], ge}.
  - Result: DIVU = `lo` (quotient), REMU = `hi` (remainder).
- Divide by zero returns results per the RISC-V spec, with no iterations: DIVU = 0xFFFFFFFF, REMU = `src_a`.
- `cnt` is cleared on accept and increments each CALC cycle; the last iteration is the one where `cnt`==31.
- In IDLE and DONE the ALU outputs are `alu_a`=0, `alu_b`=0, `alu_ctrl`=000.
- `start` is ignored in CALC and DONE. No queuing.
- `result` is registered and written on the CALC→DONE or IDLE→DONE transition.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, `alu_a`=0, `alu_b`=0, `alu_ctrl`=000, internal registers 0.
- Reset mid-operation abandons the computation; the next cycle is IDLE with all outputs at their reset values.
- Normal op, with `start` sampled at edge 0:
  - `busy`=1 during cycles 1–32.
  - `done`=1 and `result` valid in cycle 33.
  - IDLE in cycle 34, when a new `start` may be accepted.
- Divide by zero: `done`=1 in cycle 1 and `busy` never asserts.
- The ALU path is combinational within one cycle: `alu_*` outputs are registered-state decodes and `alu_result` is captured at the same edge.
- `start` asserted in the DONE cycle is dropped. The requester must hold or re-assert it in IDLE.

## Test plan
- MUL 7×6: `result`=42 with `done` pulsing exactly in cycle 33; `busy` high for exactly 32 cycles.
- 0xFFFFFFFF×0xFFFFFFFF: MUL→0x00000001, MULHU→0xFFFFFFFE. Exercises the local carry into `hi`.
- DIVU and REMU:
  - 100/7 gives DIVU→14, REMU→2.
  - 0xFFFFFFFF/0x80000001 gives DIVU→1, REMU→0x7FFFFFFE, exercising the `hi`[31] forced-subtract path.
- Divide by zero with `src_a`=0x1234: DIVU→0xFFFFFFFF and REMU→0x1234, each with `done` in cycle 1 and `busy` staying 0.
- Handshake: `start` with new operands pulsed during CALC and during DONE → ignored, first `result` unchanged; back-to-back ops are accepted only in IDLE.
- Reset mid-op: `rst` at iteration 10 of DIVU → next cycle IDLE, `busy`=0, `done`=0, `result`=0, ALU outputs 0/0/000; a fresh MUL afterwards returns the correct value.
